imm_gen_pipe: RTL and testbench

Pipelined, parametrised immediate generator for the RISC-V decode stage of the pipelined core. It decodes every base immediate format (I/S/B/U/J), plus shift-amount and CSR zimm forms, sign-extended to XLEN. Each transfer is a valid/ready handshake with one cycle of latency and an optional skid buffer. It flags opcodes that have no immediate or are illegal for XLEN, and keeps a saturating count of illegal instructions.

---
 rtl/imm_gen_pipe.sv | 173 +++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator for the decode stage.
// Decodes I/S/B/U/J, shift-amount and CSR zimm immediates, sign-extended to
// XLEN, behind a valid/ready handshake with one cycle of latency and an
// optional two-entry skid buffer. Keeps a saturating illegal-instruction count.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   in_valid, in_ready          instruction handshake
//   instruction[31:0]           raw instruction word
//   out_valid, out_ready        result handshake
//   immediate[XLEN-1:0]         decoded immediate
//   imm_type[2:0]               0 none,1 I,2 S,3 B,4 U,5 J,6 SHAMT,7 ZIMM
//   illegal                     no valid immediate for this XLEN
//   cnt_clr                     synchronous clear of illegal_count
//   illegal_count[CNT_W-1:0]    saturating count of accepted illegal words
module imm_gen_pipe #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned SKID  = 1,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instruction,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  immediate,
   output logic [2:0]       imm_type,
   output logic             illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] illegal_count
);

   if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
      $error("imm_gen_pipe: XLEN must be 32 or 64");
   end

   localparam logic [2:0] T_NONE  = 3'd0;
   localparam logic [2:0] T_I     = 3'd1;
   localparam logic [2:0] T_S     = 3'd2;
   localparam logic [2:0] T_B     = 3'd3;
   localparam logic [2:0] T_U     = 3'd4;
   localparam logic [2:0] T_J     = 3'd5;
   localparam logic [2:0] T_SHAMT = 3'd6;
   localparam logic [2:0] T_ZIMM  = 3'd7;

   typedef struct packed {
      logic [XLEN-1:0] imm;
      logic [2:0]      typ;
      logic            ill;
   } res_t;

   logic [6:0]      opcode_c;
   logic [2:0]      funct3_c;
   logic            is_shift_c;
   logic [5:0]      shamt_c;
   logic [XLEN-1:0] imm_i_c, imm_s_c, imm_b_c, imm_u_c, imm_j_c;
   logic [XLEN-1:0] imm_sh_c, imm_shw_c, imm_z_c;
   res_t            dec_c;

   assign opcode_c   = instruction[6:0];
   assign funct3_c   = instruction[14:12];
   assign is_shift_c = (funct3_c == 3'b001) || (funct3_c == 3'b101);

   // RV64 shifts carry a 6-bit shamt; RV32 keeps bit 25 for the legality check
   assign shamt_c = (XLEN == 64) ? instruction[25:20] : {1'b0, instruction[24:20]};

   // Candidate immediates, each extended straight to XLEN
   assign imm_i_c   = XLEN'($signed(instruction[31:20]));
   assign imm_s_c   = XLEN'($signed({instruction[31:25], instruction[11:7]}));
   assign imm_b_c   = XLEN'($signed({instruction[31], instruction[7], instruction[30:25],
                                     instruction[11:8], 1'b0}));
   assign imm_u_c   = XLEN'($signed({instruction[31:12], 12'b0}));
   assign imm_j_c   = XLEN'($signed({instruction[31], instruction[19:12], instruction[20],
                                     instruction[30:21], 1'b0}));
   assign imm_sh_c  = XLEN'(shamt_c);
   assign imm_shw_c = XLEN'(instruction[24:20]);
   assign imm_z_c   = XLEN'(instruction[19:15]);

   // Format select; anything not matched below is illegal with imm/type zero
   always_comb begin
      dec_c     = '0;
      dec_c.ill = 1'b1;
      if (instruction[1:0] == 2'b11) begin
         case (opcode_c)
            7'b0010011: begin
               if (is_shift_c) begin
                  if (!(XLEN == 32 && instruction[25])) begin
                     dec_c = '{imm: imm_sh_c, typ: T_SHAMT, ill: 1'b0};
                  end
               end else begin
                  dec_c = '{imm: imm_i_c, typ: T_I, ill: 1'b0};
               end
            end
            7'b0000011, 7'b1100111, 7'b0001111: dec_c = '{imm: imm_i_c, typ: T_I, ill: 1'b0};
            7'b0011011: begin
               if (XLEN == 64) begin
                  if (is_shift_c) begin
                     if (!instruction[25]) begin
                        dec_c = '{imm: imm_shw_c, typ: T_SHAMT, ill: 1'b0};
                     end
                  end else begin
                     dec_c = '{imm: imm_i_c, typ: T_I, ill: 1'b0};
                  end
               end
            end
            7'b0100011: dec_c = '{imm: imm_s_c, typ: T_S, ill: 1'b0};
            7'b1100011: dec_c = '{imm: imm_b_c, typ: T_B, ill: 1'b0};
            7'b0110111, 7'b0010111: dec_c = '{imm: imm_u_c, typ: T_U, ill: 1'b0};
            7'b1101111: dec_c = '{imm: imm_j_c, typ: T_J, ill: 1'b0};
            7'b1110011: begin
               if (funct3_c[2]) dec_c = '{imm: imm_z_c, typ: T_ZIMM, ill: 1'b0};
               else             dec_c = '{imm: '0, typ: T_NONE, ill: 1'b0};
            end
            7'b0110011: dec_c = '{imm: '0, typ: T_NONE, ill: 1'b0};
            7'b0111011: begin
               if (XLEN == 64) dec_c = '{imm: '0, typ: T_NONE, ill: 1'b0};
            end
            default: dec_c = '{imm: '0, typ: T_NONE, ill: 1'b1};
         endcase
      end
   end

   res_t out_res, skid_res;
   logic skid_full;
   logic load_out_c, accept_c;

   assign load_out_c = ~out_valid | out_ready;
   // Skid mode advertises space from a register; otherwise ready follows the output stage
   assign in_ready   = (SKID != 0) ? ~skid_full : load_out_c;
   assign accept_c   = in_valid & in_ready;

   // Output register plus skid entry; the skid entry always drains first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_res   <= '0;
         skid_full <= 1'b0;
         skid_res  <= '0;
      end else if (load_out_c) begin
         if (skid_full) begin
            out_res   <= skid_res;
            out_valid <= 1'b1;
            skid_full <= 1'b0;
         end else if (accept_c) begin
            out_res   <= dec_c;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept_c && (SKID != 0)) begin
         skid_res  <= dec_c;
         skid_full <= 1'b1;
      end
   end

   assign immediate = out_res.imm;
   assign imm_type  = out_res.typ;
   assign illegal   = out_res.ill;

   // Saturating illegal counter; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_count <= '0;
      end else if (cnt_clr) begin
         illegal_count <= '0;
      end else if (accept_c && dec_c.ill && (illegal_count != '1)) begin
         illegal_count <= illegal_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Randomised bench for imm_gen_pipe: three configurations share one stimulus
// stream; each is tracked by a queue-based reference of in-flight results.
module tb_imm_gen_pipe;

   typedef struct packed {
      logic [63:0] imm;
      logic [2:0]  typ;
      logic        ill;
   } exp_t;

   localparam int     XL_OF   [3] = '{32, 64, 32};
   localparam int     SKID_OF [3] = '{1, 0, 0};
   localparam longint CMAX_OF [3] = '{65535, 65535, 3};

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] instruction;
   logic        out_ready;
   logic        cnt_clr;

   logic [31:0] imm0, imm2;
   logic [63:0] imm1;
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;
   logic [63:0] o_imm [3];
   logic [63:0] o_cnt [3];
   logic [2:0]  o_typ [3];
   logic        o_ill [3];
   logic        o_vld [3];
   logic        o_rdy [3];

   exp_t        mq [3][$];
   logic [63:0] mcnt [3];
   int          n_chk = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(16)) u_d0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[0]),
      .instruction(instruction), .out_valid(o_vld[0]), .out_ready(out_ready),
      .immediate(imm0), .imm_type(o_typ[0]), .illegal(o_ill[0]),
      .cnt_clr(cnt_clr), .illegal_count(cnt0));

   imm_gen_pipe #(.XLEN(64), .SKID(0), .CNT_W(16)) u_d1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[1]),
      .instruction(instruction), .out_valid(o_vld[1]), .out_ready(out_ready),
      .immediate(imm1), .imm_type(o_typ[1]), .illegal(o_ill[1]),
      .cnt_clr(cnt_clr), .illegal_count(cnt1));

   imm_gen_pipe #(.XLEN(32), .SKID(0), .CNT_W(2)) u_d2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy[2]),
      .instruction(instruction), .out_valid(o_vld[2]), .out_ready(out_ready),
      .immediate(imm2), .imm_type(o_typ[2]), .illegal(o_ill[2]),
      .cnt_clr(cnt_clr), .illegal_count(cnt2));

   assign o_imm[0] = {32'b0, imm0};
   assign o_imm[1] = imm1;
   assign o_imm[2] = {32'b0, imm2};
   assign o_cnt[0] = {48'b0, cnt0};
   assign o_cnt[1] = {48'b0, cnt1};
   assign o_cnt[2] = {62'b0, cnt2};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference decode written from the ISA field definitions with plain arithmetic
   function automatic exp_t ref_dec(input logic [31:0] w, input int xl);
      exp_t   r;
      longint s, hi;
      logic [6:0] op;
      logic [2:0] f3;
      logic   shift;
      r     = '{imm: 64'd0, typ: 3'd0, ill: 1'b1};
      s     = longint'($signed(w));
      hi    = s >>> 31;
      op    = w[6:0];
      f3    = w[14:12];
      shift = (f3 == 3'd1) || (f3 == 3'd5);
      if (w[1:0] == 2'b11) begin
         case (op)
            7'h13: if (shift) begin
                      if (!(xl == 32 && w[25]))
                         r = '{imm: 64'((w >> 20) & ((xl == 64) ? 63 : 31)), typ: 3'd6, ill: 1'b0};
                   end else r = '{imm: 64'(s >>> 20), typ: 3'd1, ill: 1'b0};
            7'h03, 7'h67, 7'h0F: r = '{imm: 64'(s >>> 20), typ: 3'd1, ill: 1'b0};
            7'h1B: if (xl == 64) begin
                      if (shift) begin
                         if (!w[25]) r = '{imm: 64'((w >> 20) & 31), typ: 3'd6, ill: 1'b0};
                      end else r = '{imm: 64'(s >>> 20), typ: 3'd1, ill: 1'b0};
                   end
            7'h23: r = '{imm: 64'((s >>> 25) * 32 + longint'((w >> 7) & 31)), typ: 3'd2, ill: 1'b0};
            7'h63: r = '{imm: 64'(hi * 4096 + longint'(w[7]) * 2048 + longint'((w >> 25) & 63) * 32
                                  + longint'((w >> 8) & 15) * 2), typ: 3'd3, ill: 1'b0};
            7'h37, 7'h17: r = '{imm: 64'((s >>> 12) * 4096), typ: 3'd4, ill: 1'b0};
            7'h6F: r = '{imm: 64'(hi * 1048576 + longint'((w >> 12) & 255) * 4096
                                  + longint'(w[20]) * 2048 + longint'((w >> 21) & 1023) * 2),
                         typ: 3'd5, ill: 1'b0};
            7'h73: if (f3[2]) r = '{imm: 64'((w >> 15) & 31), typ: 3'd7, ill: 1'b0};
                   else       r = '{imm: 64'd0, typ: 3'd0, ill: 1'b0};
            7'h33: r = '{imm: 64'd0, typ: 3'd0, ill: 1'b0};
            7'h3B: if (xl == 64) r = '{imm: 64'd0, typ: 3'd0, ill: 1'b0};
            default: ;
         endcase
      end
      if (xl == 32) r.imm = r.imm & 64'h0000_0000_FFFF_FFFF;
      return r;
   endfunction

   // One clock: drive, check every DUT against its reference, advance the reference
   task automatic cycle(input logic iv, input logic [31:0] w, input logic ordy, input logic clr);
      logic rdy [3];
      exp_t e;
      in_valid = iv; instruction = w; out_ready = ordy; cnt_clr = clr;
      #1;
      for (int k = 0; k < 3; k++) begin
         rdy[k] = (SKID_OF[k] != 0) ? (mq[k].size() < 2) : (mq[k].size() == 0 || ordy);
         chk($sformatf("d%0d out_valid", k), 64'(o_vld[k]), 64'(mq[k].size() > 0));
         chk($sformatf("d%0d in_ready", k), 64'(o_rdy[k]), 64'(rdy[k]));
         chk($sformatf("d%0d illegal_count", k), o_cnt[k], mcnt[k]);
         if (mq[k].size() > 0) begin
            chk($sformatf("d%0d immediate", k), o_imm[k], mq[k][0].imm);
            chk($sformatf("d%0d imm_type", k), 64'(o_typ[k]), 64'(mq[k][0].typ));
            chk($sformatf("d%0d illegal", k), 64'(o_ill[k]), 64'(mq[k][0].ill));
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (mq[k].size() > 0 && ordy) void'(mq[k].pop_front());
         e = ref_dec(w, XL_OF[k]);
         if (iv && rdy[k]) mq[k].push_back(e);
         if (clr) mcnt[k] = 64'd0;
         else if (iv && rdy[k] && e.ill && mcnt[k] < 64'(CMAX_OF[k])) mcnt[k] = mcnt[k] + 64'd1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mq[k].delete();
         mcnt[k] = 64'd0;
      end
   endtask

   task automatic chk_idle(input string tag);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("%s d%0d out_valid", tag, k), 64'(o_vld[k]), 64'd0);
         chk($sformatf("%s d%0d immediate", tag, k), o_imm[k], 64'd0);
         chk($sformatf("%s d%0d imm_type", tag, k), 64'(o_typ[k]), 64'd0);
         chk($sformatf("%s d%0d illegal", tag, k), 64'(o_ill[k]), 64'd0);
         chk($sformatf("%s d%0d illegal_count", tag, k), o_cnt[k], 64'd0);
      end
   endtask

   function automatic logic [31:0] rnd_word();
      logic [6:0]  ops [14];
      logic [31:0] w;
      int          sel;
      ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h0F, 7'h23, 7'h63,
              7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h3B, 7'h13};
      w   = $urandom();
      sel = int'($urandom_range(0, 16));
      if (sel < 14) w[6:0] = ops[sel];
      if ($urandom_range(0, 2) == 0) w[14:12] = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b101;
      if ($urandom_range(0, 19) == 0) w[1:0] = 2'($urandom_range(0, 2));
      return w;
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; instruction = 32'd0; out_ready = 1'b0; cnt_clr = 1'b0;
      model_reset();
      #2;
      chk_idle("reset");
      for (int k = 0; k < 3; k++) chk($sformatf("reset d%0d in_ready", k), 64'(o_rdy[k]), 64'd1);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic formats and back-to-back throughput
      cycle(1'b1, 32'hFFF0_0093, 1'b1, 1'b0);
      chk("addi imm", o_imm[0], 64'hFFFF_FFFF);
      chk("addi type", 64'(o_typ[0]), 64'd1);
      chk("addi illegal", 64'(o_ill[0]), 64'd0);
      cycle(1'b1, 32'hFE00_0EE3, 1'b1, 1'b0);
      chk("beq imm", o_imm[0], 64'hFFFF_FFFC);
      chk("beq type", 64'(o_typ[0]), 64'd3);
      cycle(1'b1, 32'h1234_52B7, 1'b1, 1'b0);
      chk("lui imm", o_imm[0], 64'h1234_5000);
      chk("lui type", 64'(o_typ[0]), 64'd4);
      chk("lui b2b valid", 64'(o_vld[0]), 64'd1);
      cycle(1'b1, 32'h8000_02B7, 1'b1, 1'b0);
      chk("lui64 imm", o_imm[1], 64'hFFFF_FFFF_8000_0000);
      cycle(1'b1, 32'h0200_9093, 1'b1, 1'b0);
      chk("slli64 imm", o_imm[1], 64'h20);
      chk("slli64 type", 64'(o_typ[1]), 64'd6);
      chk("slli32 illegal", 64'(o_ill[0]), 64'd1);
      chk("slli32 imm", o_imm[0], 64'd0);
      chk("slli32 count", o_cnt[0], 64'd1);

      // Stall with three offers: skid configuration takes two, holds output stable
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'hFFF0_0093, 1'b0, 1'b0);
      cycle(1'b1, 32'hFE00_0EE3, 1'b0, 1'b0);
      chk("skid in_ready low", 64'(o_rdy[0]), 64'd0);
      cycle(1'b1, 32'h1234_52B7, 1'b0, 1'b0);
      chk("stall imm held", o_imm[0], 64'hFFFF_FFFF);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("skid drain 2nd", o_imm[0], 64'hFFFF_FFFC);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      chk("skid drained", 64'(o_vld[0]), 64'd0);

      // Counter saturation on the 2-bit configuration, then clear-wins
      cycle(1'b0, 32'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cycle(1'b1, 32'd0, 1'b1, 1'b0);
         chk($sformatf("sat count %0d", i), o_cnt[2], (i < 3) ? 64'(i + 1) : 64'd3);
      end
      cycle(1'b1, 32'd0, 1'b1, 1'b1);
      chk("clear wins", o_cnt[2], 64'd0);

      // Asynchronous reset with the skid entry occupied
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b1, 32'd0, 1'b0, 1'b0);
      cycle(1'b1, 32'd0, 1'b0, 1'b0);
      in_valid = 1'b0; out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_idle("midreset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) chk($sformatf("post-reset d%0d in_ready", k), 64'(o_rdy[k]), 64'd1);
      @(negedge clk);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);
      cycle(1'b0, 32'd0, 1'b1, 1'b0);

      // Random traffic with random backpressure
      for (int i = 0; i < 4000; i++) begin
         cycle(1'($urandom_range(0, 9) < 7), rnd_word(), 1'($urandom_range(0, 9) < 6),
               1'($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
